// File: rtl/ysyx_220066_store_buf.sv
// Posted-write store buffer between the core store path and the data-memory write port.
// Stores queue in a small circular FIFO and drain one per cycle into registered mem_* outputs.

module ysyx_220066_store_buf_match (
  input  logic        i_vld,
  input  logic [60:0] i_ent_dw,
  input  logic [7:0]  i_ent_mask,
  input  logic [60:0] i_ld_dw,
  output logic        o_hit
);
  // A mask-less store touches no bytes, so it never blocks a load.
  assign o_hit = i_vld && (i_ent_dw == i_ld_dw) && (i_ent_mask != 8'h00);
endmodule

module ysyx_220066_store_buf #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  input  logic [63:0] wr_addr,
  input  logic [7:0]  wr_mask,
  input  logic [63:0] wr_data,
  output logic        wr_ready,
  input  logic        rd_req,
  input  logic [63:0] rd_addr,
  output logic        rd_hazard,
  input  logic        mem_block,
  output logic        mem_wr,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wmask,
  output logic [63:0] mem_data,
  output logic        empty,
  output logic        overflow
);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] r_head, r_tail;
  logic [PTR_W:0]   r_count;
  logic [DEPTH-1:0] r_vld;
  logic [60:0]      r_addr [DEPTH];
  logic [7:0]       r_mask [DEPTH];
  logic [63:0]      r_data [DEPTH];

  logic             w_push, w_pop, w_mem_hit;
  logic [DEPTH-1:0] w_ent_hit;

  assign wr_ready = (r_count != CNT_FULL);
  assign w_push   = wr_valid && wr_ready;
  assign w_pop    = (r_count != '0) && !mem_block;
  assign empty    = (r_count == '0) && !mem_wr;

  // Hazard compares against registered state only, so a same-cycle push is not seen.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    ysyx_220066_store_buf_match u_match (
      .i_vld      (r_vld[g]),
      .i_ent_dw   (r_addr[g]),
      .i_ent_mask (r_mask[g]),
      .i_ld_dw    (rd_addr[63:3]),
      .o_hit      (w_ent_hit[g])
    );
  end

  ysyx_220066_store_buf_match u_mem_match (
    .i_vld      (mem_wr),
    .i_ent_dw   (mem_addr[63:3]),
    .i_ent_mask (mem_wmask),
    .i_ld_dw    (rd_addr[63:3]),
    .o_hit      (w_mem_hit)
  );

  assign rd_hazard = rd_req && ((|w_ent_hit) || w_mem_hit);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= wr_addr[63:3];
      r_mask[r_tail] <= wr_mask;
      r_data[r_tail] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_vld     <= '0;
      overflow  <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wmask <= '0;
      mem_data  <= '0;
    end else begin
      mem_wr <= w_pop;
      if (w_pop) begin
        r_head          <= r_head + PTR_ONE;
        r_vld[r_head]   <= 1'b0;
        mem_addr        <= {r_addr[r_head], 3'b000};
        mem_wmask       <= r_mask[r_head];
        mem_data        <= r_data[r_head];
      end
      if (w_push) begin
        r_tail        <= r_tail + PTR_ONE;
        r_vld[r_tail] <= 1'b1;
      end
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;
      if (wr_valid && !wr_ready) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ysyx_220066_store_buf.sv
// Scoreboard bench for the store buffer: a queue-based model predicts drains and hazards,
// and a negedge monitor compares every DUT output against it.

module tb_ysyx_220066_store_buf;
  localparam int DEPTH = 4;

  typedef struct {
    logic [63:0] a;
    logic [7:0]  m;
    logic [63:0] d;
  } st_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        wr_valid = 1'b0, rd_req = 1'b0, mem_block = 1'b0;
  logic [63:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
  logic [7:0]  wr_mask = '0;
  logic        wr_ready, rd_hazard, mem_wr, empty, overflow;
  logic [63:0] mem_addr, mem_data;
  logic [7:0]  mem_wmask;

  ysyx_220066_store_buf #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
    .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_hazard(rd_hazard),
    .mem_block(mem_block),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_data(mem_data),
    .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: contents of the buffer, the store currently on the memory port,
  // and the writes memory must see (in order).
  st_t sq[$];
  st_t exp_q[$];
  st_t infl;
  bit  infl_v = 0, m_ovf = 0;
  bit  exp_ready = 1, exp_empty = 1, exp_haz = 0;
  bit  mon_en = 0;
  int  n_tests = 0, n_fail = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit dw_hit(st_t e, logic [63:0] a);
    return (e.a[63:3] == a[63:3]) && (e.m != 8'h00);
  endfunction

  task automatic calc_comb();
    exp_ready = (sq.size() != DEPTH);
    exp_empty = (sq.size() == 0) && !infl_v;
    exp_haz   = 0;
    if (rd_req) begin
      foreach (sq[i]) if (dw_hit(sq[i], rd_addr)) exp_haz = 1;
      if (infl_v && dw_hit(infl, rd_addr)) exp_haz = 1;
    end
  endtask

  // Apply one cycle of stimulus, cross the edge, then advance the model.
  task automatic cycle(bit v, logic [63:0] a, logic [7:0] m, logic [63:0] d,
                       bit rd, logic [63:0] ra, bit blk);
    st_t e;
    bit  full, pop;
    wr_valid = v; wr_addr = a; wr_mask = m; wr_data = d;
    rd_req = rd; rd_addr = ra; mem_block = blk;
    calc_comb();
    @(posedge clk); #1;
    e.a = {a[63:3], 3'b000}; e.m = m; e.d = d;
    full = (sq.size() == DEPTH);
    pop  = (sq.size() != 0) && !blk;
    if (pop) begin
      infl = sq.pop_front();
      infl_v = 1;
      exp_q.push_back(infl);
    end else infl_v = 0;
    if (v) begin
      if (full) m_ovf = 1;
      else sq.push_back(e);
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, 64'h0, 8'h0, 64'h0, 0, 64'h0, 0);
  endtask

  initial begin
    st_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("wr_ready", wr_ready, exp_ready);
        chk("empty", empty, exp_empty);
        chk("rd_hazard", rd_hazard, exp_haz);
        chk("overflow", overflow, m_ovf);
        chk("mem_wr", mem_wr, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (mem_wr) begin
            chk("mem_addr", mem_addr, e.a);
            chk("mem_wmask", mem_wmask, e.m);
            chk("mem_data", mem_data, e.d);
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] a;
    // Reset values, with a load presented to prove the hazard is suppressed.
    #1 rd_req = 1; rd_addr = 64'h8000_0010;
    #1;
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_empty", empty, 1);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_hazard", rd_hazard, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    rst = 0; rd_req = 0;
    mon_en = 1;

    // Single store
    cycle(1, 64'h8000_0010, 8'h0F, 64'h1122_3344_5566_7788, 0, 0, 0);
    idle(4);

    // Fill with memory blocked, overflow, then drain in order
    for (int i = 1; i <= 4; i++) cycle(1, 64'h8000_0200 + 64'(i*8), 8'hFF, 64'(i), 0, 0, 1);
    cycle(1, 64'h8000_0300, 8'hFF, 64'd5, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    idle(6);

    // Steady stream with simultaneous push/pop
    for (int i = 0; i < 12; i++) cycle(1, 64'h8000_1000 + 64'(i*8), 8'h3C, 64'(100 + i), 0, 0, 0);
    idle(3);

    // Hazard against a pending, then in-flight, store
    cycle(1, 64'h8000_0100, 8'hFF, 64'hDEAD, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 64'h8000_0104, 1);
    cycle(0, 0, 0, 0, 1, 64'h8000_0108, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 64'h8000_0104, 0);
    cycle(1, 64'h8000_0400, 8'h00, 64'hBEEF, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 64'h8000_0400, 0);
    idle(3);

    // Mid-operation reset with stores queued and one in flight
    for (int i = 0; i < 3; i++) cycle(1, 64'h8000_0500 + 64'(i*8), 8'hFF, 64'(i + 7), 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0);
    wr_valid = 0; rd_req = 0; mem_block = 1;
    #2 rst = 1;
    #1;
    chk("arst_mem_wr", mem_wr, 0);
    chk("arst_empty", empty, 1);
    chk("arst_wr_ready", wr_ready, 1);
    sq.delete(); exp_q.delete(); infl_v = 0; m_ovf = 0;
    exp_ready = 1; exp_empty = 1; exp_haz = 0;
    @(posedge clk); #1;
    rst = 0;
    idle(6);

    // Randomized traffic over a small address pool so hazards hit often
    for (int i = 0; i < 400; i++) begin
      a = 64'h8000_0000 + 64'($urandom_range(0, 7) * 8) + 64'($urandom_range(0, 7));
      cycle($urandom_range(0, 9) < 7, a,
            ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom),
            {$urandom, $urandom},
            $urandom_range(0, 1),
            64'h8000_0000 + 64'($urandom_range(0, 8) * 8) + 64'($urandom_range(0, 7)),
            $urandom_range(0, 9) < 3);
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
